seven_seg_scan: RTL and testbench
=================================

Name: seven_seg_scan

Overview:
- Display-side consumer of the stopwatch's four BCD digit outputs (Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds).
- Time-multiplexes the four digits onto a common-anode 4-digit seven-segment display: active-low anodes, segments and decimal point.
- Provides tear-free frame snapshots, inter-digit ghost blanking, leading-zero blanking and a whole-display flash mode for the "timer expired" indication.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 500, cycles at start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV)
FLASH_FRAMES, 125, frames per flash half-period (>=1)
LZB, 1, 1 = leading-zero blanking enabled

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
Minutes  in  4  BCD minutes digit
Tens_Seconds  in  4  BCD tens-of-seconds digit
Ones_Seconds  in  4  BCD ones-of-seconds digit
Tenths_Seconds  in  4  BCD tenths digit
flash_en  in  1  1 = blink whole display
an  out  4  anodes, active low; an[0]=Tenths, an[1]=Ones, an[2]=Tens, an[3]=Minutes
seg  out  7  segments {g,f,e,d,c,b,a}, active low
dp  out  1  decimal point, active low
frame_tick  out  1  one-cycle pulse when a new snapshot is loaded

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
  - Internal: slot counter cnt=0, digit select sel=0, shadow digits=0, flash frame counter=0, flash phase=0 (visible).
- Slot timing:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, sel advances 0->1->2->3->0.
- Frame boundary: cycle with cnt==REFRESH_DIV-1 and sel==3. On that cycle:
  - shadow <= the four inputs.
  - frame_tick registers high for exactly one cycle.
  - Flash frame counter updates.
- Display source: only the shadow copy is displayed. Input changes mid-frame are never visible before the next frame.
- Output registration: all outputs are registered. Pins at cycle n+1 reflect internal state (cnt, sel, shadow, phase) at cycle n. Fixed latency is 1 cycle.
- Anode selection: an[sel]=0 and all other anodes=1, only when all of the following hold:
  - cnt >= BLANK_CYCLES;
  - the digit is not LZB-blanked;
  - not in flash-off phase.
  Otherwise an=4'b1111.
- Leading-zero blanking (LZB=1):
  - Digit 3 is blanked when shadow Minutes==0.
  - Digit 2 is blanked when shadow Minutes==0 and Tens==0.
  - Digits 1 and 0 are never blanked.
- Segment decode (active low) for the selected shadow digit:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10-15 display a dash, 0111111.
- Decimal point: dp=0 when sel==1 or sel==3, else 1 (separators after ones-of-seconds and after minutes). Whenever an==4'b1111, seg and dp are driven all-ones.
- Flash mode:
  - While flash_en=1, the frame counter counts frame boundaries. When it reaches FLASH_FRAMES-1 at a boundary, it clears and phase toggles.
  - phase=1 forces an=4'b1111.
  - flash_en=0 clears the counter and sets phase=0 on the next clock, so the display is visible again one cycle later.
  - A rising edge of flash_en starts in the visible phase with a full FLASH_FRAMES visible period.
- Simultaneous events: snapshot, frame_tick and phase toggle all occur on the same boundary cycle. The new phase applies from the first slot of the new frame.
- Reset mid-frame: display goes dark immediately. After release, scanning restarts at sel=0, cnt=0 and shows shadow=0.

Test Plan:
1. Params REFRESH_DIV=4, BLANK_CYCLES=1, FLASH_FRAMES=2. Release reset with inputs Min=1, Tens=2, Ones=3, Tenths=4.
   -> Frame 0 shows tenths/ones "0"/"0." with an[3:2] never low (LZB).
   -> frame_tick at cycle 15.
   -> Frame 1 shows seg 0011001, 0110000+dp, 0100100, 1111001+dp on an[0..3] in order.
   -> Each slot has 1 cycle of an=1111, then 3 cycles active.
2. Sweep Tenths_Seconds through 0-9, then 12.
   -> The an[0] slot shows the listed codes, then dash 0111111, each one frame after being applied.
3. Change Ones_Seconds 3->7 mid-frame.
   -> an[1] still shows 0110000 until after the next frame_tick, then 1111000.
4. Min=0, Tens=0 -> an[3] and an[2] stay high all frame. Min=0, Tens=3 -> an[2] active, an[3] high.
5. flash_en=1 (FLASH_FRAMES=2).
   -> 2 frames visible, then 2 frames with an=1111, repeating.
   -> Dropping flash_en during a dark frame restores normal anodes 2 cycles after the drop (one cycle to clear phase, one cycle output latency).
6. Assert reset asynchronously mid-slot with an=1101.
   -> an=1111, seg=1111111, dp=1 before the next clk edge. After release, scanning restarts at an[0].

Source files
------------

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode seven-segment scanner for the stopwatch BCD digits.
// Shadow-buffered frames, inter-digit ghost blanking, leading-zero blanking and flash.
module seven_seg_scan #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter int unsigned FLASH_FRAMES = 125,
    parameter int unsigned LZB          = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Minutes,
    input  logic [3:0] Tens_Seconds,
    input  logic [3:0] Ones_Seconds,
    input  logic [3:0] Tenths_Seconds,
    input  logic       flash_en,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int unsigned CntW = $clog2(REFRESH_DIV);
    localparam int unsigned FrmW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [CntW-1:0] CntLast  = CntW'(REFRESH_DIV - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);
    localparam logic [FrmW-1:0] FrmLast  = FrmW'(FLASH_FRAMES - 1);

    if (REFRESH_DIV < 2) begin : g_bad_div
        $error("REFRESH_DIV must be at least 2");
    end
    if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank
        $error("BLANK_CYCLES must be below REFRESH_DIV");
    end
    if (FLASH_FRAMES < 1) begin : g_bad_flash
        $error("FLASH_FRAMES must be at least 1");
    end

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0][3:0]  shadow_q, shadow_d;
    logic [FrmW-1:0]  frm_q, frm_d;
    logic             phase_q, phase_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;

    logic             slot_end;
    logic             frame_end;
    logic [3:0]       digit;
    logic             lzb_blank;
    logic             visible;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt_q == CntLast);
    assign frame_end = slot_end && (sel_q == 2'd3);

    // Scan timing, snapshot and flash phase
    always_comb begin
        cnt_d    = slot_end ? '0 : cnt_q + 1'b1;
        sel_d    = slot_end ? sel_q + 2'd1 : sel_q;
        shadow_d = shadow_q;
        tick_d   = frame_end;
        frm_d    = frm_q;
        phase_d  = phase_q;
        if (frame_end) begin
            shadow_d = {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};
        end
        if (!flash_en) begin
            frm_d   = '0;
            phase_d = 1'b0;
        end else if (frame_end) begin
            if (frm_q == FrmLast) begin
                frm_d   = '0;
                phase_d = ~phase_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    // Pin values for the current slot; registered below for a fixed one-cycle latency
    always_comb begin
        digit     = shadow_q[sel_q];
        lzb_blank = (LZB != 0) &&
                    (((sel_q == 2'd3) && (shadow_q[3] == 4'd0)) ||
                     ((sel_q == 2'd2) && (shadow_q[3] == 4'd0) && (shadow_q[2] == 4'd0)));
        visible   = (cnt_q >= BlankEnd) && !lzb_blank && !phase_q;
        an_d      = 4'b1111;
        seg_d     = 7'b1111111;
        dp_d      = 1'b1;
        if (visible) begin
            an_d[sel_q] = 1'b0;
            seg_d       = decode(digit);
            dp_d        = ~sel_q[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sel_q    <= 2'd0;
            shadow_q <= '0;
            frm_q    <= '0;
            phase_q  <= 1'b0;
            an_q     <= 4'b1111;
            seg_q    <= 7'b1111111;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            shadow_q <= shadow_d;
            frm_q    <= frm_d;
            phase_q  <= phase_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: per-frame expected pin sequences are queued
// when inputs are driven and compared cycle by cycle against the DUT.
module tb_seven_seg_scan;

    localparam int unsigned RD = 4;
    localparam int unsigned BC = 1;
    localparam int unsigned FF = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds;
    logic       flash_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          cycle = 0;
    logic [15:0] exp_sh;
    logic [12:0] sb[$];
    logic [12:0] exp_v;
    logic [12:0] act_v;

    seven_seg_scan #(
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .FLASH_FRAMES(FF),
        .LZB         (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Minutes       (Minutes),
        .Tens_Seconds  (Tens_Seconds),
        .Ones_Seconds  (Ones_Seconds),
        .Tenths_Seconds(Tenths_Seconds),
        .flash_en      (flash_en),
        .an            (an),
        .seg           (seg),
        .dp            (dp),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic latch();
        exp_sh = {Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds};
    endtask

    // Queue the 16 pin samples of one frame; entries before dark_until are forced dark
    task automatic push_frame(input logic [15:0] sh, input int dark_until);
        for (int j = 0; j < 16; j++) begin
            int         sel;
            int         cnt;
            logic [3:0] d;
            logic       blank;
            logic [3:0] a;
            logic [6:0] s;
            logic       p;
            sel   = j / 4;
            cnt   = j % 4;
            d     = sh[sel*4 +: 4];
            blank = (cnt < BC) || (j < dark_until) ||
                    (sel == 3 && sh[15:12] == 4'd0) ||
                    (sel == 2 && sh[15:12] == 4'd0 && sh[11:8] == 4'd0);
            a = 4'b1111;
            s = 7'b1111111;
            p = 1'b1;
            if (!blank) begin
                a[sel] = 1'b0;
                s      = seg_of(d);
                p      = (sel == 1 || sel == 3) ? 1'b0 : 1'b1;
            end
            sb.push_back({a, s, p, (j == 15)});
        end
    endtask

    task automatic test_reset();
        Minutes = 4'd1; Tens_Seconds = 4'd2; Ones_Seconds = 4'd3; Tenths_Seconds = 4'd4;
        flash_en = 1'b0;
        #1 reset = 1'b1;
        #2;
        n_cmp++; if (an !== 4'b1111) begin n_fail++;
            $display("FAIL reset_an got %b want 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_fail++;
            $display("FAIL reset_seg got %b want 1111111", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_fail++;
            $display("FAIL reset_dp got %b want 1", dp); end
        n_cmp++; if (frame_tick !== 1'b0) begin n_fail++;
            $display("FAIL reset_tick got %b want 0", frame_tick); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        cycle  = 0;
        exp_sh = '0;
    endtask

    task automatic test_first_frames();
        for (int f = 0; f < 2; f++) begin
            push_frame(exp_sh, 0);
            for (int j = 0; j < 16; j++) begin
                step();
                exp_v = sb.pop_front();
                act_v = {an, seg, dp, frame_tick};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL first_frames cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             cycle, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
            end
            latch();
        end
    endtask

    task automatic test_tenths_sweep();
        int vals[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12, 4};
        for (int i = 0; i < 12; i++) begin
            Tenths_Seconds = 4'(vals[i]);
            push_frame(exp_sh, 0);
            for (int j = 0; j < 16; j++) begin
                step();
                exp_v = sb.pop_front();
                act_v = {an, seg, dp, frame_tick};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL tenths_sweep cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             cycle, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
            end
            latch();
        end
    endtask

    task automatic test_midframe_change();
        for (int f = 0; f < 2; f++) begin
            push_frame(exp_sh, 0);
            for (int j = 0; j < 16; j++) begin
                step();
                exp_v = sb.pop_front();
                act_v = {an, seg, dp, frame_tick};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL midframe cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             cycle, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
                if (f == 0 && j == 5) Ones_Seconds = 4'd7;
            end
            latch();
        end
    endtask

    task automatic test_lzb();
        for (int f = 0; f < 3; f++) begin
            if (f == 0) begin
                Minutes      = 4'd0;
                Tens_Seconds = 4'd0;
            end
            if (f == 1) Tens_Seconds = 4'd3;
            push_frame(exp_sh, 0);
            for (int j = 0; j < 16; j++) begin
                step();
                exp_v = sb.pop_front();
                act_v = {an, seg, dp, frame_tick};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL lzb cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             cycle, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
            end
            latch();
        end
    endtask

    // Two visible frames, two dark, repeat; drop flash_en part-way through a dark frame
    task automatic test_flash();
        flash_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            int du;
            du = (k == 2 || k == 3) ? 16 : (k == 6) ? 6 : 0;
            push_frame(exp_sh, du);
            for (int j = 0; j < 16; j++) begin
                step();
                exp_v = sb.pop_front();
                act_v = {an, seg, dp, frame_tick};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL flash k=%0d cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             k, cycle, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
                if (k == 6 && j == 4) flash_en = 1'b0;
            end
            latch();
        end
    endtask

    task automatic test_async_reset();
        repeat (6) step();
        n_cmp++; if (an !== 4'b1101) begin n_fail++;
            $display("FAIL pre_reset_an got %b want 1101", an); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (an !== 4'b1111) begin n_fail++;
            $display("FAIL async_an got %b want 1111", an); end
        n_cmp++; if (seg !== 7'b1111111) begin n_fail++;
            $display("FAIL async_seg got %b want 1111111", seg); end
        n_cmp++; if (dp !== 1'b1) begin n_fail++;
            $display("FAIL async_dp got %b want 1", dp); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        cycle  = 0;
        exp_sh = '0;
        for (int f = 0; f < 2; f++) begin
            push_frame(exp_sh, 0);
            for (int j = 0; j < 16; j++) begin
                step();
                exp_v = sb.pop_front();
                act_v = {an, seg, dp, frame_tick};
                n_cmp++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL after_reset cyc=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             cycle, act_v[12:9], act_v[8:2], act_v[1], act_v[0],
                             exp_v[12:9], exp_v[8:2], exp_v[1], exp_v[0]);
                end
            end
            latch();
        end
    endtask

    initial begin
        test_reset();
        test_first_frames();
        test_tenths_sweep();
        test_midframe_change();
        test_lzb();
        test_flash();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
